// File: rtl/mem_master_if.sv
// ---------------------------------------------------------------------------
// mem_master_if
// Groups every handshake and bus signal of mem_master into one bundle.
//   cmd_*   : command channel from the CPU/load-store side (valid/ready)
//   wr_*    : write-data stream into the master (valid/ready)
//   rd_*    : read-data stream out of the master (valid only, no backpressure)
//   done/err: command completion pulses
//   mem_*   : strobe/ready bus to the single-port 16-bit RAM responder
// Modports:
//   master : the view taken by mem_master itself
//   slave  : the view taken by the surrounding CPU side and RAM
// ---------------------------------------------------------------------------
interface mem_master_if #(
  parameter int size_addr = 8,
  parameter int len_width = 4
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_write;
  logic [size_addr-1:0] cmd_addr;
  logic [len_width-1:0] cmd_len;

  logic [15:0]          wr_data;
  logic                 wr_valid;
  logic                 wr_ready;

  logic [15:0]          rd_data;
  logic                 rd_valid;
  logic                 done;
  logic                 err;

  logic                 mem_read;
  logic                 mem_write;
  logic [size_addr-1:0] mem_address;
  logic [15:0]          mem_wdata;
  logic [15:0]          mem_rdata;
  logic                 mem_ready_r;
  logic                 mem_ready_w;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  wr_data, wr_valid,
    input  mem_rdata, mem_ready_r, mem_ready_w,
    output cmd_ready, wr_ready, rd_data, rd_valid, done, err,
    output mem_read, mem_write, mem_address, mem_wdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output wr_data, wr_valid,
    output mem_rdata, mem_ready_r, mem_ready_w,
    input  cmd_ready, wr_ready, rd_data, rd_valid, done, err,
    input  mem_read, mem_write, mem_address, mem_wdata
  );
endinterface

// File: rtl/mem_master.sv
// ---------------------------------------------------------------------------
// mem_master
// Bus initiator for the single-port 16-bit RAM. Accepts single/burst
// commands, runs one RAM access per beat (issue cycle + wait for ready),
// streams read data out, pulls write data in, and aborts a beat whose ready
// never arrives within `timeout` wait cycles.
// Ports:
//   clk   : clock, all state on the rising edge
//   reset : asynchronous, active-low reset
//   bus   : mem_master_if.master (command, write/read streams, RAM bus)
// ---------------------------------------------------------------------------
module mem_master #(
  parameter int size_addr = 8,
  parameter int len_width = 4,
  parameter int timeout   = 15
) (
  input  logic          clk,
  input  logic          reset,
  mem_master_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_DATA,
    WR_ISSUE,
    WR_WAIT
  } state_t;

  // Last watchdog count still allowed to see a ready; one more idle wait
  // cycle past this aborts the beat.
  localparam logic [7:0] c_wdog_last = 8'(timeout - 1);

  state_t               r_state;
  logic [size_addr-1:0] r_cur_addr;
  logic [len_width-1:0] r_beats_left;
  logic [7:0]           r_wdog;
  logic                 r_cmd_ready;
  logic                 r_mem_read;
  logic                 r_mem_write;
  logic [size_addr-1:0] r_mem_address;
  logic [15:0]          r_mem_wdata;
  logic [15:0]          r_rd_data;
  logic                 r_rd_valid;
  logic                 r_done;
  logic                 r_err;

  logic [size_addr-1:0] w_next_addr;
  logic                 w_last_beat;

  // Address wraps modulo 2^size_addr by plain truncation.
  assign w_next_addr = r_cur_addr + size_addr'(1);
  assign w_last_beat = (r_beats_left == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_cur_addr    <= '0;
      r_beats_left  <= '0;
      r_wdog        <= '0;
      r_cmd_ready   <= 1'b1;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
      r_rd_data     <= '0;
      r_rd_valid    <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every branch below sees the state of
      // the previous cycle; the one-cycle pulses default low and are raised
      // only in the branch that produces them.
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;

      unique case (r_state)
        IDLE: begin
          if (bus.cmd_valid) begin
            r_cur_addr   <= bus.cmd_addr;
            r_beats_left <= bus.cmd_len;
            r_cmd_ready  <= 1'b0;
            if (bus.cmd_write) begin
              r_state <= WR_DATA;
            end else begin
              // Strobe is registered on entry so it is high during RD_ISSUE.
              r_state       <= RD_ISSUE;
              r_mem_read    <= 1'b1;
              r_mem_address <= bus.cmd_addr;
            end
          end
        end

        RD_ISSUE: begin
          r_mem_read <= 1'b0;
          r_wdog     <= '0;
          r_state    <= RD_WAIT;
        end

        RD_WAIT: begin
          if (bus.mem_ready_r) begin
            r_rd_data  <= bus.mem_rdata;
            r_rd_valid <= 1'b1;
            if (w_last_beat) begin
              r_state     <= IDLE;
              r_done      <= 1'b1;
              r_cmd_ready <= 1'b1;
            end else begin
              r_beats_left  <= r_beats_left - len_width'(1);
              r_cur_addr    <= w_next_addr;
              r_mem_read    <= 1'b1;
              r_mem_address <= w_next_addr;
              r_state       <= RD_ISSUE;
            end
          end else if (r_wdog == c_wdog_last) begin
            r_state     <= IDLE;
            r_done      <= 1'b1;
            r_err       <= 1'b1;
            r_cmd_ready <= 1'b1;
          end else begin
            r_wdog <= r_wdog + 8'd1;
          end
        end

        WR_DATA: begin
          // Unbounded wait for the producer; the watchdog is not running here.
          if (bus.wr_valid) begin
            r_mem_wdata   <= bus.wr_data;
            r_mem_write   <= 1'b1;
            r_mem_address <= r_cur_addr;
            r_state       <= WR_ISSUE;
          end
        end

        WR_ISSUE: begin
          r_mem_write <= 1'b0;
          r_wdog      <= '0;
          r_state     <= WR_WAIT;
        end

        WR_WAIT: begin
          if (bus.mem_ready_w) begin
            if (w_last_beat) begin
              r_state     <= IDLE;
              r_done      <= 1'b1;
              r_cmd_ready <= 1'b1;
            end else begin
              r_beats_left <= r_beats_left - len_width'(1);
              r_cur_addr   <= w_next_addr;
              r_state      <= WR_DATA;
            end
          end else if (r_wdog == c_wdog_last) begin
            r_state     <= IDLE;
            r_done      <= 1'b1;
            r_err       <= 1'b1;
            r_cmd_ready <= 1'b1;
          end else begin
            r_wdog <= r_wdog + 8'd1;
          end
        end

        default: begin
          r_state     <= IDLE;
          r_cmd_ready <= 1'b1;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready   = r_cmd_ready;
  // wr_ready is decoded straight from the state so data can be taken on the
  // first edge spent in WR_DATA.
  assign bus.wr_ready    = (r_state == WR_DATA);
  assign bus.rd_data     = r_rd_data;
  assign bus.rd_valid    = r_rd_valid;
  assign bus.done        = r_done;
  assign bus.err         = r_err;
  assign bus.mem_read    = r_mem_read;
  assign bus.mem_write   = r_mem_write;
  assign bus.mem_address = r_mem_address;
  assign bus.mem_wdata   = r_mem_wdata;

endmodule

// File: tb/tb_mem_master.sv
// ---------------------------------------------------------------------------
// tb_mem_master
// Drives mem_master against a behavioural model of the single-port RAM
// (ready_r/ready_w one cycle after the strobe). Stimulus pushes expected RAM
// accesses, read beats and completions into queues; an independent monitor
// pops them whenever the DUT presents a strobe, rd_valid or done.
// Cycle numbering: cyc is the value of a free-running edge counter; the
// interval after the accepting edge of a command is cycle a.
// ---------------------------------------------------------------------------
module tb_mem_master;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_master_if #(.size_addr(8), .len_width(4)) bus ();

  mem_master #(.size_addr(8), .len_width(4), .timeout(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { bit wr; logic [7:0] addr; logic [15:0] data; int cyc; } mem_exp_t;
  typedef struct { logic [15:0] data; int gap; int cyc; }                  rd_exp_t;
  typedef struct { bit err; bit with_rd; int cyc; }                         done_exp_t;

  mem_exp_t  q_mem[$];
  rd_exp_t   q_rd[$];
  done_exp_t q_done[$];

  // ---------------- RAM responder model ----------------
  logic [15:0] ram [0:255];
  bit          ram_ready_en = 1'b1;

  always @(posedge clk) begin
    bus.mem_ready_r <= bus.mem_read & ram_ready_en;
    bus.mem_ready_w <= bus.mem_write;
    if (bus.mem_read)  bus.mem_rdata <= ram[bus.mem_address];
    if (bus.mem_write) ram[bus.mem_address] <= bus.mem_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic report_unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: DUT output with nothing expected (cyc %0d)", name, cyc);
  endtask

  // ---------------- monitor / scoreboard ----------------
  int last_rd_cyc = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        if (bus.mem_read || bus.mem_write) begin
          mem_exp_t m;
          check("strobe_exclusive", {31'd0, bus.mem_read & bus.mem_write}, 32'd0);
          if (q_mem.size() == 0) begin
            report_unexpected("mem_strobe");
          end else begin
            m = q_mem.pop_front();
            check("mem_is_write", {31'd0, bus.mem_write}, {31'd0, m.wr});
            check("mem_address", {24'd0, bus.mem_address}, {24'd0, m.addr});
            if (m.wr) check("mem_wdata", {16'd0, bus.mem_wdata}, {16'd0, m.data});
            if (m.cyc >= 0) check("mem_strobe_cycle", cyc, m.cyc);
          end
        end
        if (bus.rd_valid) begin
          rd_exp_t r;
          if (q_rd.size() == 0) begin
            report_unexpected("rd_valid");
          end else begin
            r = q_rd.pop_front();
            check("rd_data", {16'd0, bus.rd_data}, {16'd0, r.data});
            if (r.gap > 0) check("rd_beat_gap", cyc - last_rd_cyc, r.gap);
            if (r.cyc >= 0) check("rd_valid_cycle", cyc, r.cyc);
          end
          last_rd_cyc = cyc;
        end
        if (bus.done) begin
          done_exp_t d;
          if (q_done.size() == 0) begin
            report_unexpected("done");
          end else begin
            d = q_done.pop_front();
            check("done_err", {31'd0, bus.err}, {31'd0, d.err});
            check("done_with_rd_valid", {31'd0, bus.rd_valid}, {31'd0, d.with_rd});
            if (d.cyc >= 0) check("done_cycle", cyc, d.cyc);
          end
        end else if (bus.err) begin
          report_unexpected("err_without_done");
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue_cmd(input bit wr, input logic [7:0] addr, input logic [3:0] len,
                           output int a);
    bit seen = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    for (int i = 0; i < 100; i++) begin
      if (bus.cmd_ready) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) report_unexpected("cmd_ready_never_high");
    @(posedge clk);
    #1;
    a = cyc;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: cmd_ready did not return within 200 cycles", name);
    end
  endtask

  // Feeds four write beats; beat `stall_beat` sees wr_valid low for five
  // cycles while the master sits in WR_DATA (-1 for none).
  task automatic drive_write(input logic [15:0] d0, input logic [15:0] d1,
                             input logic [15:0] d2, input logic [15:0] d3,
                             input int stall_beat);
    logic [15:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int k = 0; k < 4; k++) begin
      bit seen = 1'b0;
      if (k == stall_beat) begin
        bus.wr_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (bus.wr_ready) begin
            seen = 1'b1;
            break;
          end
        end
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge clk);
          check("stall_wr_ready", {31'd0, bus.wr_ready}, 32'd1);
          check("stall_no_mem_write", {31'd0, bus.mem_write}, 32'd0);
        end
        bus.wr_data  = d[k];
        bus.wr_valid = 1'b1;
      end else begin
        bus.wr_data  = d[k];
        bus.wr_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (bus.wr_ready) begin
            seen = 1'b1;
            break;
          end
        end
      end
      if (!seen) report_unexpected("wr_ready_never_high");
      @(posedge clk);
      #1;
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic single_read_beef(input string tag);
    int a;
    issue_cmd(1'b0, 8'h10, 4'd0, a);
    q_mem.push_back('{1'b0, 8'h10, 16'h0, a});
    q_rd.push_back('{16'hBEEF, 0, a + 2});
    q_done.push_back('{1'b0, 1'b1, a + 2});
    // A command offered while busy must be ignored.
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    @(negedge clk);
    check({tag, "_busy_cmd_ready"}, {31'd0, bus.cmd_ready}, 32'd0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check({tag, "_cmd_ready_cycle3"}, {31'd0, bus.cmd_ready}, 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int a;
    for (int i = 0; i < 256; i++) ram[i] = 16'h0;
    ram[8'h10] = 16'hBEEF;
    ram[8'hFE] = 16'hA0FE;
    ram[8'hFF] = 16'hA0FF;
    ram[8'h00] = 16'hA000;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_data   = '0;
    bus.wr_valid  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("rst_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    check("rst_pulses", {29'd0, bus.rd_valid, bus.done, bus.err}, 32'd0);
    check("rst_wr_ready", {31'd0, bus.wr_ready}, 32'd0);
    check("rst_regs", {bus.mem_address, bus.mem_wdata}, 32'd0);
    check("rst_rd_data", {16'd0, bus.rd_data}, 32'd0);
    reset = 1'b1;

    // Single read with cycle-exact latency
    single_read_beef("single");
    wait_idle("single_read");

    // Burst write 0x20..0x23, wr_valid held high
    issue_cmd(1'b1, 8'h20, 4'd3, a);
    q_mem.push_back('{1'b1, 8'h20, 16'h1111, a + 1});
    q_mem.push_back('{1'b1, 8'h21, 16'h2222, -1});
    q_mem.push_back('{1'b1, 8'h22, 16'h3333, -1});
    q_mem.push_back('{1'b1, 8'h23, 16'h4444, -1});
    q_done.push_back('{1'b0, 1'b0, -1});
    drive_write(16'h1111, 16'h2222, 16'h3333, 16'h4444, -1);
    wait_idle("burst_write");

    // Read-back burst: beats two cycles apart
    issue_cmd(1'b0, 8'h20, 4'd3, a);
    q_mem.push_back('{1'b0, 8'h20, 16'h0, a});
    q_mem.push_back('{1'b0, 8'h21, 16'h0, a + 2});
    q_mem.push_back('{1'b0, 8'h22, 16'h0, a + 4});
    q_mem.push_back('{1'b0, 8'h23, 16'h0, a + 6});
    q_rd.push_back('{16'h1111, 0, a + 2});
    q_rd.push_back('{16'h2222, 2, -1});
    q_rd.push_back('{16'h3333, 2, -1});
    q_rd.push_back('{16'h4444, 2, a + 8});
    q_done.push_back('{1'b0, 1'b1, a + 8});
    wait_idle("burst_read");

    // Write backpressure on beat 2
    issue_cmd(1'b1, 8'h50, 4'd3, a);
    q_mem.push_back('{1'b1, 8'h50, 16'hCAFE, -1});
    q_mem.push_back('{1'b1, 8'h51, 16'hF00D, -1});
    q_mem.push_back('{1'b1, 8'h52, 16'h1234, -1});
    q_mem.push_back('{1'b1, 8'h53, 16'h5678, -1});
    q_done.push_back('{1'b0, 1'b0, -1});
    drive_write(16'hCAFE, 16'hF00D, 16'h1234, 16'h5678, 1);
    wait_idle("write_backpressure");

    // Address wrap 0xFE, 0xFF, 0x00
    issue_cmd(1'b0, 8'hFE, 4'd2, a);
    q_mem.push_back('{1'b0, 8'hFE, 16'h0, a});
    q_mem.push_back('{1'b0, 8'hFF, 16'h0, a + 2});
    q_mem.push_back('{1'b0, 8'h00, 16'h0, a + 4});
    q_rd.push_back('{16'hA0FE, 0, -1});
    q_rd.push_back('{16'hA0FF, 2, -1});
    q_rd.push_back('{16'hA000, 2, -1});
    q_done.push_back('{1'b0, 1'b1, a + 6});
    wait_idle("wrap");

    // Timeout: RD_WAIT occupies cycles a+1..a+4 without ready, so the abort
    // edge ends cycle a+4 and done/err show in cycle a+5; no rd_valid.
    ram_ready_en = 1'b0;
    issue_cmd(1'b0, 8'h40, 4'd5, a);
    q_mem.push_back('{1'b0, 8'h40, 16'h0, a});
    q_done.push_back('{1'b1, 1'b0, a + 5});
    wait_idle("timeout");
    check("timeout_cmd_ready_cycle", cyc, a + 5);
    repeat (3) @(negedge clk);
    ram_ready_en = 1'b1;

    // Reset in RD_WAIT of beat 1
    issue_cmd(1'b0, 8'h30, 4'd3, a);
    q_mem.push_back('{1'b0, 8'h30, 16'h0, a});
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    check("midrst_pulses", {29'd0, bus.rd_valid, bus.done, bus.err}, 32'd0);
    check("midrst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("midrst_mem_address", {24'd0, bus.mem_address}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    single_read_beef("after_reset");
    wait_idle("after_reset");

    repeat (5) @(negedge clk);
    check("q_mem_drained", q_mem.size(), 32'd0);
    check("q_rd_drained", q_rd.size(), 32'd0);
    check("q_done_drained", q_done.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
